// File: rtl/mem_port_arbiter_if.sv
// Bundle of all handshake/bus signals around mem_port_arbiter.
//   if_*  : instruction-fetch requester port (req/addr in, rdata/ack/excpt out)
//   d_*   : data requester port (req/addr/wdata/we in, rdata/ack/excpt out)
//   m_*   : single-ported memory side (req/addr/wdata/we out, rdata/ack/excpt in)
//   busy  : arbiter is serving a transaction
// Modport slave is the arbiter's view; modport master is the environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 30
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;
    logic              if_excpt;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_we;
    logic [31:0]       d_rdata;
    logic              d_ack;
    logic              d_excpt;

    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_we;
    logic [31:0]       m_rdata;
    logic              m_ack;
    logic              m_excpt;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_wdata, d_we, m_rdata, m_ack, m_excpt,
        output if_rdata, if_ack, if_excpt, d_rdata, d_ack, d_excpt,
        output m_req, m_addr, m_wdata, m_we, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_wdata, d_we, m_rdata, m_ack, m_excpt,
        input  if_rdata, if_ack, if_excpt, d_rdata, d_ack, d_excpt,
        input  m_req, m_addr, m_wdata, m_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of one single-ported memory.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_port_arbiter_if.slave carrying requester and memory signals
// One transaction in flight at a time; ties alternate, with fetch winning the
// first tie after reset. A transaction with no memory ack for TIMEOUT cycles
// completes with a fault.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StServI, StServD} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;  // 0 = fetch, 1 = data
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        we_q, we_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              if_excpt_q, if_excpt_d;
    logic              d_excpt_q, d_excpt_d;
    logic              if_elig, d_elig;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_excpt_d   = if_excpt_q;
        d_excpt_d    = d_excpt_q;
        // A requester still holding req during its own ack cycle is a stale request.
        if_elig      = bus.if_req & ~if_ack_q;
        d_elig       = bus.d_req & ~d_ack_q;

        unique case (state_q)
            StIdle: begin
                if (if_elig && (!d_elig || last_grant_q)) begin
                    state_d      = StServI;
                    last_grant_d = 1'b0;
                    cnt_d        = 8'd0;
                    addr_d       = bus.if_addr;
                    wdata_d      = 32'd0;
                    we_d         = 4'b0000;
                end else if (d_elig) begin
                    state_d      = StServD;
                    last_grant_d = 1'b1;
                    cnt_d        = 8'd0;
                    addr_d       = bus.d_addr;
                    wdata_d      = bus.d_wdata;
                    we_d         = bus.d_we;
                end
            end
            StServI: begin
                if (bus.m_ack) begin
                    state_d    = StIdle;
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus.m_rdata;
                    if_excpt_d = bus.m_excpt;
                end else if (cnt_q == TimeoutLast) begin
                    state_d    = StIdle;
                    if_ack_d   = 1'b1;
                    if_rdata_d = 32'd0;
                    if_excpt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StServD: begin
                if (bus.m_ack) begin
                    state_d   = StIdle;
                    d_ack_d   = 1'b1;
                    d_rdata_d = (we_q == 4'b0000) ? bus.m_rdata : 32'd0;
                    d_excpt_d = bus.m_excpt;
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = StIdle;
                    d_ack_d   = 1'b1;
                    d_rdata_d = 32'd0;
                    d_excpt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            we_q         <= 4'b0000;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            if_excpt_q   <= 1'b0;
            d_excpt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_excpt_q   <= if_excpt_d;
            d_excpt_q    <= d_excpt_d;
        end
    end

    // Memory side is driven only from holding registers; zeroed whenever not in use.
    assign bus.m_req    = (state_q != StIdle);
    assign bus.m_addr   = (state_q != StIdle) ? addr_q : '0;
    assign bus.m_wdata  = (state_q == StServD) ? wdata_q : 32'd0;
    assign bus.m_we     = (state_q == StServD) ? we_q : 4'b0000;
    assign bus.busy     = (state_q != StIdle);

    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.if_excpt = if_excpt_q;
    assign bus.d_excpt  = d_excpt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 30;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who is being served, how long it has waited, and what
    // each requester should currently see.
    int              owner;      // 0 none, 1 fetch, 2 data
    int              waited;     // service cycles elapsed without memory ack
    bit              last_was_d; // last winner was data
    logic [AW-1:0]   cap_addr;
    logic [31:0]     cap_wdata;
    logic [3:0]      cap_we;
    bit              e_if_ack, e_d_ack, e_if_ex, e_d_ex;
    logic [31:0]     e_if_rdata, e_d_rdata;
    bit              dead;

    task automatic model_reset();
        owner = 0; waited = 0; last_was_d = 1'b1;
        cap_addr = '0; cap_wdata = '0; cap_we = '0;
        e_if_ack = 0; e_d_ack = 0; e_if_ex = 0; e_d_ex = 0;
        e_if_rdata = '0; e_d_rdata = '0;
    endtask

    task automatic check_all();
        check("m_req",    bus.m_req, owner != 0);
        check("busy",     bus.busy, owner != 0);
        check("m_addr",   bus.m_addr, (owner != 0) ? cap_addr : '0);
        check("m_we",     bus.m_we, (owner == 2) ? cap_we : 4'b0000);
        check("m_wdata",  bus.m_wdata, (owner == 2) ? cap_wdata : 32'd0);
        check("if_ack",   bus.if_ack, e_if_ack);
        check("d_ack",    bus.d_ack, e_d_ack);
        check("if_rdata", bus.if_rdata, e_if_rdata);
        check("d_rdata",  bus.d_rdata, e_d_rdata);
        check("ack_excl", bus.if_ack & bus.d_ack, 1'b0);
        if (e_if_ack) check("if_excpt", bus.if_excpt, e_if_ex);
        if (e_d_ack)  check("d_excpt", bus.d_excpt, e_d_ex);
    endtask

    // Requesters keep req up until acked; the one being served scrambles its
    // inputs to show they are ignored once captured.
    task automatic drive();
        if (bus.if_req) begin
            if (e_if_ack) begin
                if ($urandom_range(0, 1) == 0) bus.if_req = 1'b0;
                else bus.if_addr = AW'($urandom);
            end else if (owner == 1 && $urandom_range(0, 1) == 0) begin
                bus.if_addr = AW'($urandom);
            end
        end else if ($urandom_range(0, 9) < 6) begin
            bus.if_req  = 1'b1;
            bus.if_addr = AW'($urandom);
        end

        if (bus.d_req) begin
            if (e_d_ack) begin
                if ($urandom_range(0, 1) == 0) bus.d_req = 1'b0;
                else begin
                    bus.d_addr  = AW'($urandom);
                    bus.d_wdata = $urandom;
                    bus.d_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                end
            end else if (owner == 2 && $urandom_range(0, 1) == 0) begin
                bus.d_addr  = AW'($urandom);
                bus.d_wdata = $urandom;
                bus.d_we    = 4'($urandom);
            end
        end else if ($urandom_range(0, 9) < 6) begin
            bus.d_req   = 1'b1;
            bus.d_addr  = AW'($urandom);
            bus.d_wdata = $urandom;
            bus.d_we    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        end

        bus.m_ack   = dead ? 1'b0 : ($urandom_range(0, 3) == 0);
        bus.m_rdata = $urandom;
        bus.m_excpt = ($urandom_range(0, 7) == 0);
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic step();
        bit n_if_ack = 0;
        bit n_d_ack  = 0;
        if (owner == 0) begin
            bit wi = bus.if_req && !e_if_ack;
            bit wd = bus.d_req && !e_d_ack;
            if (wi && wd) begin
                if (last_was_d) wd = 0;
                else wi = 0;
            end
            if (wi) begin
                owner = 1; waited = 0; last_was_d = 0;
                cap_addr = bus.if_addr; cap_wdata = '0; cap_we = '0;
            end else if (wd) begin
                owner = 2; waited = 0; last_was_d = 1;
                cap_addr = bus.d_addr; cap_wdata = bus.d_wdata; cap_we = bus.d_we;
            end
        end else begin
            bit          done = 0;
            logic [31:0] rd   = '0;
            bit          ex   = 0;
            if (bus.m_ack) begin
                done = 1;
                rd   = (cap_we != 4'b0000) ? 32'd0 : bus.m_rdata;
                ex   = bus.m_excpt;
            end else if (waited + 1 == int'(TO)) begin
                done = 1; rd = '0; ex = 1;
            end else begin
                waited++;
            end
            if (done) begin
                if (owner == 1) begin
                    n_if_ack = 1; e_if_rdata = rd; e_if_ex = ex;
                end else begin
                    n_d_ack = 1; e_d_rdata = rd; e_d_ex = ex;
                end
                owner = 0;
            end
        end
        e_if_ack = n_if_ack;
        e_d_ack  = n_d_ack;
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_we = '0;
        bus.m_rdata = '0; bus.m_ack = 1'b0; bus.m_excpt = 1'b0;
        dead = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        check("rst_if_excpt", bus.if_excpt, 1'b0);
        check("rst_d_excpt", bus.d_excpt, 1'b0);
        rst = 1'b0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            check_all();
            if (cyc > 100 && $urandom_range(0, 249) == 0) begin
                // Asynchronous reset, possibly mid-transaction: effect must be immediate.
                rst = 1'b1;
                #1;
                check("rst_m_req", bus.m_req, 1'b0);
                check("rst_acks", {bus.if_ack, bus.d_ack}, 2'b00);
                check("rst_m_addr", bus.m_addr, '0);
                model_reset();
                @(negedge clk);
                check_all();
                rst = 1'b0;
            end
            dead = (cyc % 300) >= 260;
            drive();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
